counter_sweep_ctrl: RTL and testbench

//  Sequencer for the loadable up/down counter datapath. On a start request it

---
 rtl/counter_sweep_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// counter_sweep_ctrl
//   Triangle/scan sequencer that owns a loadable up/down counter. An accepted
//   start captures the bounds and sweep count, loads the low bound, then runs
//   lo -> hi -> lo the programmed number of times, then pulses done.
//
// Ports
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous active-high reset
//   start       in   1      begin a sequence (only looked at in IDLE)
//   abort       in   1      stop a running sequence, back to IDLE, no done
//   hold        in   1      freeze counter/FSM while counting (UP/DOWN)
//   lo          in   WIDTH  low bound, captured on accepted start
//   hi          in   WIDTH  high bound, captured on accepted start
//   sweeps      in   SWP_W  number of sweeps, captured on accepted start
//   out         out  WIDTH  counter value
//   mode        out  1      1 while counting up
//   load        out  1      1 in the single load cycle
//   busy        out  1      1 while loading or counting
//   done        out  1      one-cycle completion pulse
//   err         out  1      one-cycle pulse when a start is rejected
//   sweep_left  out  SWP_W  sweeps remaining including the current one
// -----------------------------------------------------------------------------
module counter_sweep_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SWP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [SWP_W-1:0] sweeps,
    output logic [WIDTH-1:0] out,
    output logic             mode,
    output logic             load,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [SWP_W-1:0] sweep_left
);

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] S_IDLE = 3'd0;
    localparam logic [ST_W-1:0] S_LOAD = 3'd1;
    localparam logic [ST_W-1:0] S_UP   = 3'd2;
    localparam logic [ST_W-1:0] S_DOWN = 3'd3;
    localparam logic [ST_W-1:0] S_DONE = 3'd4;

    logic [ST_W-1:0]  state,  state_nxt;
    logic [WIDTH-1:0] lo_q,   lo_nxt;
    logic [WIDTH-1:0] hi_q,   hi_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic [SWP_W-1:0] sweep_left_nxt;
    logic             err_nxt;
    logic             mode_nxt;
    logic             load_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    logic [WIDTH-1:0] out_inc;
    logic [WIDTH-1:0] out_dec;
    logic             start_ok;

    // Counter neighbours; lo<hi at capture keeps these from wrapping in use.
    assign out_inc  = out + WIDTH'(1);
    assign out_dec  = out - WIDTH'(1);
    assign start_ok = (lo < hi) && (sweeps != '0);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            lo_q       <= '0;
            hi_q       <= '0;
            out        <= '0;
            sweep_left <= '0;
            mode       <= 1'b0;
            load       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            lo_q       <= lo_nxt;
            hi_q       <= hi_nxt;
            out        <= out_nxt;
            sweep_left <= sweep_left_nxt;
            mode       <= mode_nxt;
            load       <= load_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt      = state;
        lo_nxt         = lo_q;
        hi_nxt         = hi_q;
        out_nxt        = out;
        sweep_left_nxt = sweep_left;
        err_nxt        = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        lo_nxt         = lo;
                        hi_nxt         = hi;
                        sweep_left_nxt = sweeps;
                        state_nxt      = S_LOAD;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                // hold has no effect here; abort leaves out at its old value.
                if (abort) begin
                    sweep_left_nxt = '0;
                    state_nxt      = S_IDLE;
                end else begin
                    out_nxt   = lo_q;
                    state_nxt = S_UP;
                end
            end

            S_UP: begin
                if (abort) begin
                    sweep_left_nxt = '0;
                    state_nxt      = S_IDLE;
                end else if (!hold) begin
                    out_nxt = out_inc;
                    if (out_inc == hi_q) begin
                        state_nxt = S_DOWN;
                    end
                end
            end

            S_DOWN: begin
                if (abort) begin
                    sweep_left_nxt = '0;
                    state_nxt      = S_IDLE;
                end else if (!hold) begin
                    out_nxt = out_dec;
                    // Reaching lo closes a sweep: either finish or bounce back up.
                    if (out_dec == lo_q) begin
                        if (sweep_left == SWP_W'(1)) begin
                            sweep_left_nxt = '0;
                            state_nxt      = S_DONE;
                        end else begin
                            sweep_left_nxt = sweep_left - SWP_W'(1);
                            state_nxt      = S_UP;
                        end
                    end
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                sweep_left_nxt = '0;
                state_nxt      = S_IDLE;
            end
        endcase

        // Status flags are registered copies of the next-state decode.
        mode_nxt = (state_nxt == S_UP);
        load_nxt = (state_nxt == S_LOAD);
        busy_nxt = (state_nxt == S_LOAD) || (state_nxt == S_UP) || (state_nxt == S_DOWN);
        done_nxt = (state_nxt == S_DONE);
    end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_sweep_ctrl
//   Bench for counter_sweep_ctrl. A reference model predicts every cycle from
//   a precomputed trace of the whole sequence (built from the bounds with plain
//   loops); a vector table and directed sequences cover the corner cases.
// -----------------------------------------------------------------------------
module tb_counter_sweep_ctrl;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned SWP_W = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic             hold;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [SWP_W-1:0] sweeps;
    logic [WIDTH-1:0] out;
    logic             mode;
    logic             load;
    logic             busy;
    logic             done;
    logic             err;
    logic [SWP_W-1:0] sweep_left;

    counter_sweep_ctrl #(.WIDTH(WIDTH), .SWP_W(SWP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .hold       (hold),
        .lo         (lo),
        .hi         (hi),
        .sweeps     (sweeps),
        .out        (out),
        .mode       (mode),
        .load       (load),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .sweep_left (sweep_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observable outputs bundled for whole-cycle comparison.
    typedef struct packed {
        logic [WIDTH-1:0] out;
        logic             mode;
        logic             load;
        logic             busy;
        logic             done;
        logic             err;
        logic [SWP_W-1:0] sl;
    } obs_t;

    typedef struct {
        logic             rst;
        logic             start;
        logic             abort;
        logic             hold;
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;
        logic [SWP_W-1:0] sweeps;
        obs_t             exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    obs_t cur;
    obs_t trace[$];

    function automatic obs_t mk(int o, bit m, bit l, bit b, bit d, bit e, int s);
        obs_t r;
        r.out  = WIDTH'(o);
        r.mode = m;
        r.load = l;
        r.busy = b;
        r.done = d;
        r.err  = e;
        r.sl   = SWP_W'(s);
        return r;
    endfunction

    function automatic obs_t dut_obs();
        return mk(int'(out), mode, load, busy, done, err, int'(sweep_left));
    endfunction

    // Whole accepted sequence laid out cycle by cycle from the bounds.
    function automatic void build_trace(int l, int h, int s, int cur_out);
        trace.delete();
        trace.push_back(mk(cur_out, 0, 1, 1, 0, 0, s));
        for (int k = s; k >= 1; k--) begin
            for (int v = l; v < h; v++) trace.push_back(mk(v, 1, 0, 1, 0, 0, k));
            for (int v = h; v > l; v--) trace.push_back(mk(v, 0, 0, 1, 0, 0, k));
        end
        trace.push_back(mk(l, 0, 0, 0, 1, 0, 0));
    endfunction

    function automatic void model_step(bit r, bit st, bit ab, bit hd, int l, int h, int s);
        obs_t nx;
        if (r) begin
            nx = mk(0, 0, 0, 0, 0, 0, 0);
            trace.delete();
        end else if (cur.busy) begin
            if (ab) begin
                nx = mk(int'(cur.out), 0, 0, 0, 0, 0, 0);
                trace.delete();
            end else if (hd && !cur.load) begin
                nx = cur;
            end else if (trace.size() > 0) begin
                nx = trace.pop_front();
            end else begin
                nx = mk(int'(cur.out), 0, 0, 0, 0, 0, 0);
            end
        end else if (cur.done) begin
            nx = mk(int'(cur.out), 0, 0, 0, 0, 0, 0);
        end else begin
            nx = mk(int'(cur.out), 0, 0, 0, 0, 0, 0);
            if (st) begin
                if (l < h && s != 0) begin
                    build_trace(l, h, s, int'(cur.out));
                    nx = trace.pop_front();
                end else begin
                    nx.err = 1'b1;
                end
            end
        end
        cur = nx;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare after the edge.
    task automatic step(input bit r, input bit st, input bit ab, input bit hd,
                        input int l, input int h, input int s);
        obs_t got;
        rst    = r;
        start  = st;
        abort  = ab;
        hold   = hd;
        lo     = WIDTH'(l);
        hi     = WIDTH'(h);
        sweeps = SWP_W'(s);
        @(posedge clk);
        model_step(r, st, ab, hd, l, h, s);
        #1;
        got = dut_obs();
        n_checks++;
        if (got !== cur) begin
            n_fail++;
            $display("FAIL model: got out=%0d mode=%0b load=%0b busy=%0b done=%0b err=%0b sl=%0d expected out=%0d mode=%0b load=%0b busy=%0b done=%0b err=%0b sl=%0d at %0t",
                     got.out, got.mode, got.load, got.busy, got.done, got.err, got.sl,
                     cur.out, cur.mode, cur.load, cur.busy, cur.done, cur.err, cur.sl, $time);
        end
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)));
    endtask

    // Idle-steps until done is seen; returns steps taken and hi visits.
    task automatic run_to_done(input string name, input int budget, input int hv,
                               output int steps, output int hits);
        steps = 0;
        hits  = 0;
        while (!done && steps < budget) begin
            idle_step();
            steps++;
            if (busy && int'(out) == hv) hits++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: done=%0b expected 1 within %0d cycles", name, done, budget);
        end
    endtask

    vec_t vt[16];

    initial begin
        int steps;
        int hits;
        int lat_a;
        int lat_b;
        int guard;

        rst = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0;
        lo = '0; hi = '0; sweeps = '0;
        cur = mk(0, 0, 0, 0, 0, 0, 0);

        // Directed vectors: single sweep 2..5 then rejected starts.
        vt[0]  = '{1, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0)};
        vt[1]  = '{0, 1, 0, 0, 2, 5, 1, mk(0, 0, 1, 1, 0, 0, 1)};
        vt[2]  = '{0, 0, 0, 0, 9, 1, 0, mk(2, 1, 0, 1, 0, 0, 1)};
        vt[3]  = '{0, 1, 0, 0, 0, 0, 0, mk(3, 1, 0, 1, 0, 0, 1)};
        vt[4]  = '{0, 0, 0, 0, 0, 0, 0, mk(4, 1, 0, 1, 0, 0, 1)};
        vt[5]  = '{0, 0, 0, 0, 0, 0, 0, mk(5, 0, 0, 1, 0, 0, 1)};
        vt[6]  = '{0, 0, 0, 0, 0, 0, 0, mk(4, 0, 0, 1, 0, 0, 1)};
        vt[7]  = '{0, 0, 0, 0, 0, 0, 0, mk(3, 0, 0, 1, 0, 0, 1)};
        vt[8]  = '{0, 1, 0, 0, 1, 8, 2, mk(2, 0, 0, 0, 1, 0, 0)};
        vt[9]  = '{0, 0, 0, 0, 0, 0, 0, mk(2, 0, 0, 0, 0, 0, 0)};
        vt[10] = '{0, 1, 0, 0, 7, 7, 1, mk(2, 0, 0, 0, 0, 1, 0)};
        vt[11] = '{0, 0, 0, 0, 0, 0, 0, mk(2, 0, 0, 0, 0, 0, 0)};
        vt[12] = '{0, 1, 0, 0, 3, 8, 0, mk(2, 0, 0, 0, 0, 1, 0)};
        vt[13] = '{0, 0, 1, 1, 0, 0, 0, mk(2, 0, 0, 0, 0, 0, 0)};
        vt[14] = '{0, 1, 0, 0, 8, 3, 2, mk(2, 0, 0, 0, 0, 1, 0)};
        vt[15] = '{0, 0, 0, 0, 0, 0, 0, mk(2, 0, 0, 0, 0, 0, 0)};

        for (int i = 0; i < 16; i++) begin
            step(vt[i].rst, vt[i].start, vt[i].abort, vt[i].hold,
                 int'(vt[i].lo), int'(vt[i].hi), int'(vt[i].sweeps));
            n_checks++;
            if (dut_obs() !== vt[i].exp) begin
                n_fail++;
                $display("FAIL vec%0d: got %h expected %h", i, dut_obs(), vt[i].exp);
            end
        end

        // Full-range triple sweep: hi visited three times, latency 2+90.
        step(0, 1, 0, 0, 0, 15, 3);
        run_to_done("full_range", 200, 15, steps, hits);
        chk("full_range_latency", steps + 1, 92);
        chk("full_range_hi_hits", hits, 3);
        idle_step();

        // Hold four cycles at out=5 delays done by exactly four cycles.
        step(0, 1, 0, 0, 1, 9, 2);
        run_to_done("nohold", 100, 99, steps, hits);
        lat_a = steps + 1;
        chk("nohold_latency", lat_a, 34);
        idle_step();
        step(0, 1, 0, 0, 1, 9, 2);
        lat_b = 1;
        guard = 0;
        while (!(mode && int'(out) == 5) && guard < 20) begin
            idle_step();
            lat_b++;
            guard++;
        end
        chk("hold_reach_5", int'(out), 5);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 1, 0, 0, 0);
            lat_b++;
            chk("hold_frozen", int'(out), 5);
        end
        run_to_done("hold", 100, 99, steps, hits);
        lat_b += steps;
        chk("hold_delay", lat_b - lat_a, 4);
        idle_step();

        // Abort (with hold) during DOWN at out=6, then immediate restart.
        step(0, 1, 0, 0, 2, 9, 1);
        guard = 0;
        while (!(busy && !mode && !load && int'(out) == 6) && guard < 30) begin
            idle_step();
            guard++;
        end
        chk("abort_reach_6", int'(out), 6);
        step(0, 0, 1, 1, 0, 0, 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_out", int'(out), 6);
        chk("abort_done", int'(done), 0);
        chk("abort_sl", int'(sweep_left), 0);
        step(0, 1, 0, 0, 1, 3, 1);
        chk("restart_load", int'(load), 1);
        run_to_done("restart", 20, 99, steps, hits);
        chk("restart_latency", steps + 1, 6);
        idle_step();

        // Start while busy is ignored; reset mid-UP wins over start.
        step(0, 1, 0, 0, 0, 10, 1);
        guard = 0;
        while (!(mode && int'(out) == 4) && guard < 20) begin
            idle_step();
            guard++;
        end
        step(0, 1, 0, 0, 3, 5, 2);
        chk("busy_start_out", int'(out), 5);
        chk("busy_start_err", int'(err), 0);
        chk("busy_start_sl", int'(sweep_left), 1);
        step(1, 1, 0, 0, 1, 6, 1);
        chk("rst_out", int'(out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_load", int'(load), 0);
        idle_step();

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            bit r;
            bit st;
            bit ab;
            bit hd;
            r  = ($urandom_range(0, 299) == 0);
            st = ($urandom_range(0, 3) == 0);
            ab = ($urandom_range(0, 59) == 0);
            hd = ($urandom_range(0, 7) == 0);
            step(r, st, ab, hd, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)));
            // Counter must never leave the captured window while counting.
            if (busy && !load && (trace.size() > 0 || cur.busy)) begin
                n_checks++;
                if (mode && out == '1) begin
                    n_fail++;
                    $display("FAIL wrap: out=%0d expected below max while counting up", out);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
